// File: rtl/iob_fp_add_arb.sv
// Round-robin sharing of one pipelined FP adder among N_REQ requesters.
// A tag pipeline tracks the owner of each in-flight operation and routes its result back.
module iob_fp_add_arb #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned EXP_W   = 8,
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ADD_LAT = 5,
    parameter int unsigned ID_W    = $clog2(N_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [N_REQ*DATA_W-1:0]  req_op_a_i,
    input  logic [N_REQ*DATA_W-1:0]  req_op_b_i,
    output logic                     add_start_o,
    output logic [DATA_W-1:0]        add_op_a_o,
    output logic [DATA_W-1:0]        add_op_b_o,
    input  logic                     add_done_i,
    input  logic [DATA_W-1:0]        add_res_i,
    output logic [N_REQ-1:0]         rsp_valid_o,
    output logic [DATA_W-1:0]        rsp_data_o,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int unsigned CNT_W = $clog2(ADD_LAT + 3);

    if (N_REQ < 2 || ADD_LAT < 1 || EXP_W == 0 || EXP_W >= DATA_W) begin : g_bad_cfg
        $error("iob_fp_add_arb: invalid parameter set");
    end

    logic [ID_W-1:0]              ptr_q;
    logic [ID_W-1:0]              idx;
    logic [ID_W-1:0]              gnt_id;
    logic                         accept;
    logic [ADD_LAT:0]             tag_v_q;
    logic [ADD_LAT:0][ID_W-1:0]   tag_id_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [CNT_W-1:0]             cnt_d;
    logic                         head_v;
    logic [ID_W-1:0]              head_id;

    assign head_v  = tag_v_q[ADD_LAT];
    assign head_id = tag_id_q[ADD_LAT];

    // Search from ptr+1 with wrap; grants are suppressed while disabled or in reset.
    always_comb begin
        req_ready_o = '0;
        gnt_id      = '0;
        idx         = '0;
        accept      = 1'b0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = ID_W'((32'(ptr_q) + i) % N_REQ);
            if (!accept && en_i && !rst_i && req_valid_i[idx]) begin
                accept      = 1'b1;
                gnt_id      = idx;
                req_ready_o = N_REQ'(1) << idx;
            end
        end
    end

    // Accepts and responses landing together cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && !(|rsp_valid_o)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!accept && (|rsp_valid_o)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q       <= ID_W'(N_REQ - 1);
            add_start_o <= 1'b0;
            add_op_a_o  <= '0;
            add_op_b_o  <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
            rsp_id_o    <= '0;
            cnt_q       <= '0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            add_start_o <= accept;
            if (accept) begin
                ptr_q      <= gnt_id;
                add_op_a_o <= req_op_a_i[gnt_id*DATA_W +: DATA_W];
                add_op_b_o <= req_op_b_i[gnt_id*DATA_W +: DATA_W];
            end
            // Stage 0 lines up with add_start_o, the head with add_done_i.
            tag_v_q  <= {tag_v_q[ADD_LAT-1:0], accept};
            tag_id_q <= {tag_id_q[ADD_LAT-1:0], gnt_id};

            rsp_valid_o <= '0;
            if (add_done_i && head_v) begin
                rsp_valid_o <= N_REQ'(1) << head_id;
                rsp_data_o  <= add_res_i;
                rsp_id_o    <= head_id;
            end
            if (add_done_i != head_v) begin
                err_o <= 1'b1;
            end
            cnt_q  <= cnt_d;
            busy_o <= (cnt_d != '0);
        end
    end

endmodule

// File: tb/tb_iob_fp_add_arb.sv
// Directed bench for iob_fp_add_arb with a 5-cycle exact FP adder model.
module tb_iob_fp_add_arb;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned N_REQ   = 4;
    localparam int unsigned ID_W    = 2;

    logic                    clk_i;
    logic                    rst_i;
    logic                    en_i;
    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ-1:0]        req_ready_o;
    logic [N_REQ*DATA_W-1:0] req_op_a_i;
    logic [N_REQ*DATA_W-1:0] req_op_b_i;
    logic                    add_start_o;
    logic [DATA_W-1:0]       add_op_a_o;
    logic [DATA_W-1:0]       add_op_b_o;
    logic                    add_done_i;
    logic [DATA_W-1:0]       add_res_i;
    logic [N_REQ-1:0]        rsp_valid_o;
    logic [DATA_W-1:0]       rsp_data_o;
    logic [ID_W-1:0]         rsp_id_o;
    logic                    busy_o;
    logic                    err_o;

    logic                    inj_done;
    int                      n_chk;
    int                      n_pass;

    // Lane k computes A[k]+B[k]; sums hand-computed in exp_res.
    logic [31:0] lane_a  [4] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40400000};
    logic [31:0] lane_b  [4] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000};
    logic [31:0] exp_res [4] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h40800000};

    iob_fp_add_arb dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_a_i  (req_op_a_i),
        .req_op_b_i  (req_op_b_i),
        .add_start_o (add_start_o),
        .add_op_a_o  (add_op_a_o),
        .add_op_b_o  (add_op_b_o),
        .add_done_i  (add_done_i),
        .add_res_i   (add_res_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_id_o    (rsp_id_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52];
        if (e == 11'd0) return {d[63], 31'd0};
        return {d[63], 8'(e - 11'd896), d[51:29]};
    endfunction

    // Adder model: done five cycles after start, reset with the same rst_i.
    logic [4:0]  m_v;
    logic [31:0] m_r [5];
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_v <= '0;
        end else begin
            m_v    <= {m_v[3:0], add_start_o};
            m_r[0] <= r2f(f2r(add_op_a_o) + f2r(add_op_b_o));
            for (int k = 1; k < 5; k++) m_r[k] <= m_r[k-1];
        end
    end
    assign add_done_i = m_v[4] | inj_done;
    assign add_res_i  = m_r[4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic to_next();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        req_valid_i = '0;
        en_i        = 1'b1;
        inj_done    = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic drain();
        req_valid_i = '0;
        repeat (9) to_next();
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_i  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_op_a_i[k*DATA_W +: DATA_W] = lane_a[k];
            req_op_b_i[k*DATA_W +: DATA_W] = lane_b[k];
        end

        // Reset values
        do_reset();
        @(negedge clk_i);
        check("rst_ready", 64'(req_ready_o), 64'h0);
        check("rst_start", 64'(add_start_o), 64'h0);
        check("rst_op_a", 64'(add_op_a_o), 64'h0);
        check("rst_rsp_v", 64'(rsp_valid_o), 64'h0);
        check("rst_rsp_d", 64'(rsp_data_o), 64'h0);
        check("rst_rsp_id", 64'(rsp_id_o), 64'h0);
        check("rst_busy", 64'(busy_o), 64'h0);
        check("rst_err", 64'(err_o), 64'h0);
        to_next();

        // Single op on lane 2: start at t+1, response at t+7
        req_valid_i = 4'b0100;
        @(negedge clk_i);
        check("s_ready", 64'(req_ready_o), 64'h4);
        to_next();
        req_valid_i = '0;
        @(negedge clk_i);
        check("s_start", 64'(add_start_o), 64'h1);
        check("s_op_a", 64'(add_op_a_o), 64'h3F800000);
        check("s_op_b", 64'(add_op_b_o), 64'h40000000);
        check("s_busy1", 64'(busy_o), 64'h1);
        for (int c = 2; c <= 8; c++) begin
            to_next();
            @(negedge clk_i);
            check("s_busy", 64'(busy_o), (c <= 7) ? 64'h1 : 64'h0);
            check("s_rsp_v", 64'(rsp_valid_o), (c == 7) ? 64'h4 : 64'h0);
            if (c == 2) check("s_start_off", 64'(add_start_o), 64'h0);
            if (c == 3) check("s_op_hold", 64'(add_op_a_o), 64'h3F800000);
            if (c == 7) begin
                check("s_rsp_d", 64'(rsp_data_o), 64'h40400000);
                check("s_rsp_id", 64'(rsp_id_o), 64'h2);
            end
        end
        to_next();

        // All lanes valid from reset: back-to-back grants and responses
        do_reset();
        req_valid_i = 4'hF;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_i);
            check("rr_ready", 64'(req_ready_o), 64'(4'b0001 << (c % 4)));
            if (c >= 7) begin
                check("rr_rsp_v", 64'(rsp_valid_o), 64'(4'b0001 << ((c - 7) % 4)));
                check("rr_rsp_id", 64'(rsp_id_o), 64'((c - 7) % 4));
                check("rr_rsp_d", 64'(rsp_data_o), 64'(exp_res[(c - 7) % 4]));
            end else begin
                check("rr_rsp_idle", 64'(rsp_valid_o), 64'h0);
            end
            to_next();
        end
        drain();
        @(negedge clk_i);
        check("rr_busy_end", 64'(busy_o), 64'h0);
        check("rr_err_end", 64'(err_o), 64'h0);
        to_next();

        // Lanes 0 and 2 with ptr=0: alternate 2,0,2,0
        do_reset();
        req_valid_i = 4'b0001;
        @(negedge clk_i);
        check("alt_pre", 64'(req_ready_o), 64'h1);
        to_next();
        req_valid_i = 4'b0101;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            check("alt_ready", 64'(req_ready_o), (c % 2 == 0) ? 64'h4 : 64'h1);
            to_next();
        end
        drain();

        // en_i drops after two accepts; in-flight ops still respond
        do_reset();
        req_valid_i = 4'hF;
        for (int c = 0; c < 12; c++) begin
            en_i = (c < 2);
            @(negedge clk_i);
            check("en_ready", 64'(req_ready_o), (c == 0) ? 64'h1 : (c == 1) ? 64'h2 : 64'h0);
            check("en_start", 64'(add_start_o), (c == 1 || c == 2) ? 64'h1 : 64'h0);
            check("en_rsp_v", 64'(rsp_valid_o), (c == 7) ? 64'h1 : (c == 8) ? 64'h2 : 64'h0);
            check("en_busy", 64'(busy_o), (c >= 1 && c <= 8) ? 64'h1 : 64'h0);
            to_next();
        end
        en_i = 1'b1;
        drain();

        // Asynchronous reset mid-cycle with three ops in flight
        do_reset();
        req_valid_i = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("ar_ready", 64'(req_ready_o), 64'(4'b0001 << c));
            to_next();
        end
        req_valid_i = '0;
        to_next();
        #2 rst_i = 1'b1;
        #1;
        check("ar_start", 64'(add_start_o), 64'h0);
        check("ar_op_a", 64'(add_op_a_o), 64'h0);
        check("ar_op_b", 64'(add_op_b_o), 64'h0);
        check("ar_rsp_v", 64'(rsp_valid_o), 64'h0);
        check("ar_rsp_id", 64'(rsp_id_o), 64'h0);
        check("ar_busy", 64'(busy_o), 64'h0);
        check("ar_err", 64'(err_o), 64'h0);
        to_next();
        rst_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            check("ar_no_rsp", 64'(rsp_valid_o), 64'h0);
            to_next();
        end
        check("ar_err_after", 64'(err_o), 64'h0);
        req_valid_i = 4'hF;
        @(negedge clk_i);
        check("ar_first_gnt", 64'(req_ready_o), 64'h1);
        to_next();
        drain();

        // Spurious done with nothing in flight sets the sticky error
        do_reset();
        @(negedge clk_i);
        check("sp_err_pre", 64'(err_o), 64'h0);
        to_next();
        inj_done = 1'b1;
        to_next();
        inj_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check("sp_err", 64'(err_o), 64'h1);
            check("sp_rsp_v", 64'(rsp_valid_o), 64'h0);
            to_next();
        end
        do_reset();
        @(negedge clk_i);
        check("sp_err_clr", 64'(err_o), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
